// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC -> imem req/gnt/rvalid -> small FIFO -> decode valid/ready.
// Optional misaligned-PC fault entries when FETCH_ALIGN_CHK_EN is defined.
module fetch_unit #(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

`ifdef FETCH_ALIGN_CHK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDiscard} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, rptr_q;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] inst_mem  [DEPTH];
  logic        fault_mem [DEPTH];

  logic        push, pop, misaligned, space_now, space_after;
  logic [31:0] push_pc, push_inst;
  logic        push_fault;

  assign misaligned  = AlignChk && (pc_in[1:0] != 2'b00);
  assign pop         = inst_valid & inst_ready;
  assign count_d     = flush ? '0 : count_q + CW'(push) - CW'(pop);
  // The in-flight request already owns a slot, so space is judged on the post-push count.
  assign space_now   = count_q < DepthC;
  assign space_after = count_d < DepthC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (space_now && !flush && !misaligned) state_d = StReq;
      end
      StReq: begin
        if (imem_gnt)   state_d = flush ? StDiscard : StWait;
        else if (flush) state_d = StIdle;
      end
      StWait: begin
        if (imem_rvalid) state_d = (!flush && space_after) ? StReq : StIdle;
        else if (flush)  state_d = StDiscard;
      end
      StDiscard: begin
        if (imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (state_d == StReq && state_q != StReq) addr_d = {pc_in[31:2], 2'b00};
  end

  always_comb begin
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    push       = 1'b0;
    push_pc    = addr_q;
    push_inst  = imem_rdata;
    push_fault = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Misaligned PC becomes a fault entry without touching memory.
        if (space_now && !flush && misaligned) begin
          push       = 1'b1;
          push_pc    = pc_in;
          push_inst  = RESET_INST;
          push_fault = 1'b1;
          pc_advance = 1'b1;
        end
      end
      StReq: begin
        imem_req   = 1'b1;
        pc_advance = imem_gnt & ~flush;
      end
      StWait: push = imem_rvalid & ~flush;
      default: ;
    endcase
  end

  assign imem_addr = imem_req ? addr_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q]    <= push_pc;
      inst_mem[wptr_q]  <= push_inst;
      fault_mem[wptr_q] <= push_fault;
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? inst_mem[rptr_q] : RESET_INST;
  assign inst_pc    = inst_valid ? pc_mem[rptr_q] : 32'h0;
  assign inst_fault = AlignChk && inst_valid && fault_mem[rptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_INST = 32'h0000_0000;

  logic        clk, rst, flush, imem_gnt, imem_rvalid, inst_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_advance, imem_req, inst_valid, inst_fault;
  logic [31:0] imem_addr, inst, inst_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_INST(RESET_INST)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_advance(pc_advance), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  ent_t mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; inst_ready = 1'b0; pc_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check1({tag, "_adv"}, pc_advance, 1'b0);
    check1({tag, "_valid"}, inst_valid, 1'b0);
    check({tag, "_inst"}, inst, RESET_INST);
    check({tag, "_pc"}, inst_pc, 32'h0);
    check1({tag, "_fault"}, inst_fault, 1'b0);
  endtask

  // Memory always grants; data returns the cycle after the grant.
  task automatic run_auto(input int n, output int grants);
    logic        pend, g, adv;
    logic [31:0] pend_addr, a;
    pend = 1'b0; pend_addr = '0; grants = 0;
    for (int k = 0; k < n; k++) begin
      imem_gnt = 1'b1;
      imem_rvalid = pend;
      imem_rdata = 32'hA000_0000 | pend_addr;
      #1;
      adv = pc_advance; g = imem_req & imem_gnt; a = imem_addr;
      tick();
      pend = g; pend_addr = a;
      if (g) grants++;
      if (adv) pc_in = pc_in + 32'd4;
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
  endtask

  initial begin
    vec_t        vecs[4];
    int          grants, fetched;
    logic        pend, live, adv;
    logic [31:0] req_pc;
    ent_t        tmp;

    vecs[0] = '{32'h0000_0040, 32'h2008_0005, 32'h0000_0040, 32'h2008_0005, 32'h0000_0040};
    vecs[1] = '{32'h0000_1000, 32'h8C82_0000, 32'h0000_1000, 32'h8C82_0000, 32'h0000_1000};
    vecs[2] = '{32'hFFFF_FFFC, 32'h1234_5678, 32'hFFFF_FFFC, 32'h1234_5678, 32'hFFFF_FFFC};
    vecs[3] = '{32'hBFC0_0000, 32'h3C08_BFC0, 32'hBFC0_0000, 32'h3C08_BFC0, 32'hBFC0_0000};

    // Single-transaction best-case latency per vector.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      pc_in = vecs[i].pc; inst_ready = 1'b1;
      #1;
      check_reset_outputs("reset");
      tick();
      imem_gnt = 1'b1;
      #1;
      check1("vec_req", imem_req, 1'b1);
      check("vec_addr", imem_addr, vecs[i].exp_addr);
      check1("vec_adv", pc_advance, 1'b1);
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = vecs[i].rdata;
      #1;
      check1("vec_adv_once", pc_advance, 1'b0);
      check1("vec_early_valid", inst_valid, 1'b0);
      tick();
      imem_rvalid = 1'b0;
      #1;
      check1("vec_valid", inst_valid, 1'b1);
      check("vec_inst", inst, vecs[i].exp_inst);
      check("vec_inst_pc", inst_pc, vecs[i].exp_pc);
      check1("vec_fault", inst_fault, 1'b0);
    end

    // Full queue: two entries, no third request, in-order drain, resume at 0x8.
    do_reset();
    pc_in = 32'h0;
    run_auto(12, grants);
    check("full_grants", grants, 32'd2);
    check("full_pc", pc_in, 32'h8);
    #1;
    check1("full_no_req", imem_req, 1'b0);
    check1("full_valid", inst_valid, 1'b1);
    inst_ready = 1'b1;
    #1;
    check("drain0_pc", inst_pc, 32'h0);
    check("drain0_inst", inst, 32'hA000_0000);
    tick();
    check("drain1_pc", inst_pc, 32'h4);
    check("drain1_inst", inst, 32'hA000_0004);
    tick();
    check1("resume_req", imem_req, 1'b1);
    check("resume_addr", imem_addr, 32'h8);
    check1("resume_empty", inst_valid, 1'b0);

    // Flush in WAIT, late data dropped, refetch from the redirect target.
    do_reset();
    pc_in = 32'h80; inst_ready = 1'b1;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b1;
    #1;
    check1("fwait_adv", pc_advance, 1'b0);
    tick();
    flush = 1'b0; pc_in = 32'h100; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check1("fwait_discard_req", imem_req, 1'b0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check1("fwait_valid", inst_valid, 1'b0);
    tick();
    check1("fwait_req", imem_req, 1'b1);
    check("fwait_addr", imem_addr, 32'h100);
    check1("fwait_valid2", inst_valid, 1'b0);

    // Flush coincident with grant.
    do_reset();
    pc_in = 32'h300; inst_ready = 1'b1;
    tick();
    imem_gnt = 1'b1; flush = 1'b1;
    #1;
    check1("fgnt_req", imem_req, 1'b1);
    check1("fgnt_adv", pc_advance, 1'b0);
    tick();
    imem_gnt = 1'b0; flush = 1'b0; pc_in = 32'h400; imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_2222;
    #1;
    check1("fgnt_discard_req", imem_req, 1'b0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check1("fgnt_valid", inst_valid, 1'b0);
    check1("fgnt_req_idle", imem_req, 1'b0);
    tick();
    check1("fgnt_refetch", imem_req, 1'b1);
    check("fgnt_addr", imem_addr, 32'h400);

    // Reset while in WAIT with one queued entry.
    do_reset();
    pc_in = 32'h200; inst_ready = 1'b0;
    tick();
    imem_gnt = 1'b1;
    tick();
    pc_in = 32'h204; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_0001;
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    #1;
    check1("rw_queued", inst_valid, 1'b1);
    check("rw_addr", imem_addr, 32'h204);
    tick();
    imem_gnt = 1'b0; pc_in = 32'h208; rst = 1'b1;
    tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    check_reset_outputs("rw_reset");
    tick();
    imem_rvalid = 1'b0;
    #1;
    check1("rw_late_ignored", inst_valid, 1'b0);
    check1("rw_restart_req", imem_req, 1'b1);
    check("rw_restart_addr", imem_addr, 32'h208);

    // Misaligned PC.
    do_reset();
    pc_in = 32'h42; inst_ready = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    #1;
    check1("mis_adv", pc_advance, 1'b1);
    check1("mis_no_req", imem_req, 1'b0);
    tick();
    check1("mis_no_req2", imem_req, 1'b0);
    check1("mis_valid", inst_valid, 1'b1);
    check1("mis_fault", inst_fault, 1'b1);
    check("mis_inst", inst, 32'h0);
    check("mis_pc", inst_pc, 32'h42);
`else
    tick();
    imem_gnt = 1'b1;
    #1;
    check1("mis_req", imem_req, 1'b1);
    check("mis_addr", imem_addr, 32'h40);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2408_0001;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check1("mis_valid", inst_valid, 1'b1);
    check1("mis_fault", inst_fault, 1'b0);
    check("mis_pc", inst_pc, 32'h40);
`endif

    // Randomized run against a queue model of fetched-but-unconsumed instructions.
    do_reset();
    mq.delete();
    pend = 1'b0; live = 1'b0; req_pc = '0; fetched = 0;
    pc_in = $urandom & 32'h0000_0FFC;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush       = ($urandom_range(11) == 0);
      imem_gnt    = ($urandom_range(2) != 0);
      inst_ready  = ($urandom_range(2) != 0);
      imem_rvalid = pend && ($urandom_range(1) == 1);
      imem_rdata  = $urandom;
      #1;
      if (mq.size() != 0) begin
        check1("rnd_valid", inst_valid, 1'b1);
        check("rnd_inst", inst, mq[0].inst);
        check("rnd_inst_pc", inst_pc, mq[0].pc);
      end else begin
        check1("rnd_valid", inst_valid, 1'b0);
        check("rnd_inst_empty", inst, RESET_INST);
        check("rnd_pc_empty", inst_pc, 32'h0);
      end
      check1("rnd_fault", inst_fault, 1'b0);
      check1("rnd_adv", pc_advance, imem_req & imem_gnt & ~flush);
      check1("rnd_req_busy", imem_req && (pend || mq.size() >= DEPTH), 1'b0);
      if (imem_req) check("rnd_addr", imem_addr, {pc_in[31:2], 2'b00});
      if (mq.size() != 0 && inst_ready) tmp = mq.pop_front();
      if (imem_rvalid) begin
        if (live && !flush) begin
          mq.push_back('{pc: req_pc, inst: imem_rdata});
          fetched++;
        end
        pend = 1'b0;
      end
      if (flush) begin
        mq.delete();
        live = 1'b0;
      end
      if (imem_req && imem_gnt) begin
        pend = 1'b1; live = !flush; req_pc = {pc_in[31:2], 2'b00};
      end
      adv = pc_advance;
      tick();
      if (flush) pc_in = $urandom & 32'h0000_FFFC;
      else if (adv) pc_in = pc_in + 32'd4;
    end
    check1("rnd_progress", fetched > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly downstream of the PC register.
- Takes the current PC, issues word requests to instruction memory over a req/gnt + rvalid handshake, and buffers returned instructions with their PCs in a small FIFO.
- Presents buffered instructions to decode over a valid/ready interface.
- Pulses pc_advance to tell next-PC logic when the current PC has been consumed; supports pipeline flush on redirect.

Parameters:
- DEPTH, 2, fetch queue entries; power of two, >= 2.
- RESET_INST, 32'h0000_0000, value driven on inst when the queue is empty (MIPS nop).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  32  current PC from the PC register.
- pc_advance  output  1  one-cycle pulse: PC consumed, next-PC logic may update.
- flush  input  1  discard all fetched or in-flight instructions (branch/jump redirect).
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  request word address.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode accepts head.
- inst  output  32  head instruction.
- inst_pc  output  32  PC of head instruction.
- inst_fault  output  1  head entry is a misaligned-fetch fault (0 unless FETCH_ALIGN_CHK_EN).

Behaviour:
- Reset (rst=1 at clk edge, priority over everything):
  - state=IDLE, count=0, read/write pointers=0.
  - imem_req=0, imem_addr=0, pc_advance=0, inst_valid=0, inst=RESET_INST, inst_pc=0, inst_fault=0.
  - Reset mid-transaction abandons the request; any imem_rvalid arriving in IDLE or REQ is ignored.
- Space condition: count < DEPTH, counting the in-flight slot; at most one outstanding request.
- FSM states: IDLE, REQ, WAIT, DISCARD.
  - IDLE: if space and !flush, capture addr_q = {pc_in[31:2],2'b00} and go to REQ.
  - REQ: imem_req=1, imem_addr=addr_q, held stable until granted.
    - gnt & !flush: go to WAIT; pc_advance=1 combinationally that cycle.
    - gnt & flush: go to DISCARD; pc_advance=0.
    - !gnt & flush: imem_req drops next cycle; go to IDLE.
  - WAIT: on imem_rvalid, push {addr_q, imem_rdata, fault=0}.
    - Next state is REQ (capturing pc_in) if space remains after the push and !flush; otherwise IDLE.
    - flush without rvalid: go to DISCARD. flush with rvalid: data dropped, go to IDLE.
  - DISCARD: wait for imem_rvalid, drop the data, go to IDLE. flush here has no further effect.
- pc_advance: never asserted outside a REQ-state grant; never asserted while flush=1.
- Queue:
  - Outputs come from the head register: an entry pushed at edge N is visible as inst_valid at N+1.
  - Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Full queue: no request issued.
  - Empty queue: inst_valid=0, inst=RESET_INST, inst_pc=0, inst_fault=0.
- Flush: next cycle count=0, pointers reset, inst_valid=0. A pop in the flush cycle is still honoured (decode saw it).
- Best-case latency: pc_in stable at cycle 0 (IDLE), grant cycle 1, rvalid cycle 2, inst_valid cycle 3. Sustained throughput is 1 instruction per 2 cycles.
- Address arithmetic: no increment inside the block. PC sequencing stays in next-PC logic; addr_q is a captured copy only.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - In IDLE, if pc_in[1:0] != 0 with space and !flush, no memory request is issued.
  - The block pushes {pc_in, RESET_INST, fault=1} directly, pulses pc_advance for that cycle, and stays in IDLE.
  - inst_fault follows the head entry.
- Undefined: pc_in[1:0] is ignored (forced to 00 in imem_addr) and inst_fault is tied 0.

Test Plan:
- Reset then pc_in=0x0000_0040, gnt at first REQ cycle, rvalid one cycle later with rdata=0x2008_0005, inst_ready=1 → pc_advance pulses once, imem_addr=0x40, inst_valid=1 with inst=0x2008_0005, inst_pc=0x40 exactly 3 cycles after reset release.
- inst_ready=0 with DEPTH=2, sequential PCs 0x0,0x4,0x8 → two entries queued, no third imem_req while full; raising inst_ready pops 0x0 then 0x4 in order and fetching resumes at 0x8.
- flush asserted in WAIT, then rvalid with 0xDEAD_BEEF → data dropped (DISCARD), inst_valid stays 0, next request uses the new pc_in=0x100.
- flush in the same cycle as imem_gnt → pc_advance=0, state DISCARD, the following rvalid is dropped, queue empty.
- rst pulsed while in WAIT with 1 queued entry → all outputs at reset values next cycle, a late rvalid is ignored, and fetch restarts from pc_in.
- With FETCH_ALIGN_CHK_EN, pc_in=0x0000_0042 → no imem_req, entry with inst_fault=1, inst=0x0, inst_pc=0x42; without the macro → imem_addr=0x40, inst_fault=0.
